// File: rtl/tmr_mon_pkg.sv
// Shared defaults for the tmrErr monitor slice.
//   N_SRC_DEF      : default number of tmrErr sources
//   CNT_WIDTH_DEF  : default event counter / threshold width
//   sum_width()    : width used for the saturating add (one carry bit above the counter)
package tmr_mon_pkg;

    localparam int N_SRC_DEF     = 8;
    localparam int CNT_WIDTH_DEF = 16;

    function automatic int sum_width(input int cnt_width);
        return cnt_width + 1;
    endfunction

endpackage

// File: rtl/tmr_err_popcount.sv
// Combinational population count.
//   vec : N-bit input vector
//   cnt : number of set bits in vec, 0..N
module tmr_err_popcount #(
    parameter int N = 8
) (
    input  logic [N-1:0]             vec,
    output logic [$clog2(N+1)-1:0]   cnt
);

    localparam int CW = $clog2(N+1);

    always_comb begin
        cnt = '0;
        for (int i = 0; i < N; i++) begin
            cnt = cnt + CW'(vec[i]);
        end
    end

endmodule

// File: rtl/tmr_err_monitor.sv
// SEU-correction event monitor fed by the voter tmrErr lines.
// Detects rising edges on each tmrErr line, keeps a saturating event counter,
// sticky per-source flags, a snapshot / read-and-clear path and a threshold alarm.
//   clk, rstn          : clock, asynchronous active-low reset
//   enable             : count events when 1; freeze counter/flags when 0
//   clear              : zero counter/flags/overflow (events in this cycle still count)
//   tmrErr_i           : raw tmrErr lines
//   snapReq            : capture pre-edge counter/flags into snapshot registers
//   threshold          : alarm level, 0 disables
//   errCount/errFlags  : live count and sticky flags
//   overflow           : sticky saturation indicator
//   alarm              : registered errCount >= threshold (threshold != 0)
//   snapCount/snapFlags/snapValid : snapshot registers and update pulse
module tmr_err_monitor
    import tmr_mon_pkg::*;
#(
    parameter int N_SRC     = N_SRC_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [N_SRC-1:0]     tmrErr_i,
    input  logic                 snapReq,
    input  logic [CNT_WIDTH-1:0] threshold,
    output logic [CNT_WIDTH-1:0] errCount,
    output logic [N_SRC-1:0]     errFlags,
    output logic                 overflow,
    output logic                 alarm,
    output logic [CNT_WIDTH-1:0] snapCount,
    output logic [N_SRC-1:0]     snapFlags,
    output logic                 snapValid
);

    localparam int PC_W  = $clog2(N_SRC+1);
    localparam int SUM_W = sum_width(CNT_WIDTH);

    logic [N_SRC-1:0]     err_q, err_qq;
    logic [N_SRC-1:0]     edge_w;
    logic [PC_W-1:0]      inc_w;
    logic [SUM_W-1:0]     sum_w;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [N_SRC-1:0]     flags_q, flags_d;
    logic                 ovf_q, ovf_d;
    logic                 alarm_q, alarm_d;
    logic [CNT_WIDTH-1:0] snap_cnt_q;
    logic [N_SRC-1:0]     snap_flags_q;
    logic                 snap_vld_q;

    // Edges seen while disabled are dropped here, which also gives clear its
    // "inc/edge masked when disabled" behaviour for free.
    assign edge_w = enable ? (err_q & ~err_qq) : '0;

    tmr_err_popcount #(.N(N_SRC)) u_popcount (
        .vec (edge_w),
        .cnt (inc_w)
    );

    // Clear restarts the add from zero so same-cycle events land in the fresh count.
    assign sum_w = (clear ? SUM_W'(0) : SUM_W'(cnt_q)) + SUM_W'(inc_w);

    always_comb begin
        cnt_d   = cnt_q;
        flags_d = flags_q;
        ovf_d   = ovf_q;
        if (enable || clear) begin
            flags_d = (clear ? '0 : flags_q) | edge_w;
            ovf_d   = clear ? 1'b0 : ovf_q;
            if (sum_w[CNT_WIDTH]) begin
                cnt_d = '1;
                ovf_d = 1'b1;
            end else begin
                cnt_d = sum_w[CNT_WIDTH-1:0];
            end
        end
        alarm_d = (threshold != '0) && (cnt_q >= threshold);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_q        <= '0;
            err_qq       <= '0;
            cnt_q        <= '0;
            flags_q      <= '0;
            ovf_q        <= 1'b0;
            alarm_q      <= 1'b0;
            snap_cnt_q   <= '0;
            snap_flags_q <= '0;
            snap_vld_q   <= 1'b0;
        end else begin
            err_q      <= tmrErr_i;
            err_qq     <= err_q;
            cnt_q      <= cnt_d;
            flags_q    <= flags_d;
            ovf_q      <= ovf_d;
            alarm_q    <= alarm_d;
            snap_vld_q <= snapReq;
            // Snapshot takes the pre-edge values, so snapReq+clear is an atomic read-and-clear.
            if (snapReq) begin
                snap_cnt_q   <= cnt_q;
                snap_flags_q <= flags_q;
            end
        end
    end

    assign errCount  = cnt_q;
    assign errFlags  = flags_q;
    assign overflow  = ovf_q;
    assign alarm     = alarm_q;
    assign snapCount = snap_cnt_q;
    assign snapFlags = snap_flags_q;
    assign snapValid = snap_vld_q;

endmodule

// File: tb/tb_tmr_err_monitor.sv
module tb_tmr_err_monitor;

    logic        clk = 1'b0;
    logic        rstn;
    logic        enable;
    logic        clear;
    logic [7:0]  tmrErr;
    logic        snapReq;
    logic [15:0] threshold;

    logic [15:0] errCount, snapCount;
    logic [7:0]  errFlags, snapFlags;
    logic        overflow, alarm, snapValid;

    logic [3:0]  errCount4, snapCount4;
    logic [7:0]  errFlags4, snapFlags4;
    logic        overflow4, alarm4, snapValid4;

    int nchk  = 0;
    int nfail = 0;

    always #5 clk = ~clk;

    tmr_err_monitor #(.N_SRC(8), .CNT_WIDTH(16)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .clear(clear),
        .tmrErr_i(tmrErr), .snapReq(snapReq), .threshold(threshold),
        .errCount(errCount), .errFlags(errFlags), .overflow(overflow),
        .alarm(alarm), .snapCount(snapCount), .snapFlags(snapFlags),
        .snapValid(snapValid)
    );

    tmr_err_monitor #(.N_SRC(8), .CNT_WIDTH(4)) dut4 (
        .clk(clk), .rstn(rstn), .enable(enable), .clear(clear),
        .tmrErr_i(tmrErr), .snapReq(snapReq), .threshold(threshold[3:0]),
        .errCount(errCount4), .errFlags(errFlags4), .overflow(overflow4),
        .alarm(alarm4), .snapCount(snapCount4), .snapFlags(snapFlags4),
        .snapValid(snapValid4)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Raise lines for one sampled cycle; the count reflects it on return.
    task automatic pulse(input logic [7:0] v);
        tmrErr = v;
        cyc();
        tmrErr = 8'h00;
        cyc();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0; enable = 1'b0; clear = 1'b0; tmrErr = 8'h00;
        snapReq = 1'b0; threshold = 16'd0;
        cyc(); cyc();
        nchk++;
        if ({errCount, errFlags, overflow, alarm, snapCount, snapFlags, snapValid} !== 51'd0) begin
            nfail++;
            $display("FAIL reset_outputs: got cnt=%h flg=%h ovf=%b alm=%b sc=%h sf=%h sv=%b, want all 0",
                     errCount, errFlags, overflow, alarm, snapCount, snapFlags, snapValid);
        end
        nchk++;
        if ({errCount4, errFlags4, overflow4} !== 13'd0) begin
            nfail++;
            $display("FAIL reset_outputs_w4: got cnt=%h flg=%h ovf=%b, want 0", errCount4, errFlags4, overflow4);
        end
        rstn = 1'b1; enable = 1'b1;
        cyc();
    endtask

    task automatic test_single_pulse();
        tmrErr = 8'h01;
        cyc();
        nchk++;
        if (errCount !== 16'd0) begin
            nfail++; $display("FAIL pulse_latency: got %0d want 0 one edge after", errCount);
        end
        tmrErr = 8'h00;
        cyc();
        nchk++;
        if (errCount !== 16'd1 || errFlags !== 8'h01) begin
            nfail++; $display("FAIL pulse_count: got cnt=%0d flg=%h want 1/01", errCount, errFlags);
        end
        cyc();
    endtask

    task automatic test_hold();
        do_clear();
        nchk++;
        if (errCount !== 16'd0 || errFlags !== 8'h00) begin
            nfail++; $display("FAIL clear_idle: got cnt=%0d flg=%h want 0/00", errCount, errFlags);
        end
        tmrErr = 8'hFF;
        for (int i = 0; i < 10; i++) cyc();
        nchk++;
        if (errCount !== 16'd8 || errFlags !== 8'hFF) begin
            nfail++; $display("FAIL hold_once: got cnt=%0d flg=%h want 8/FF", errCount, errFlags);
        end
        tmrErr = 8'h00;
        cyc(); cyc();
        nchk++;
        if (errCount !== 16'd8) begin
            nfail++; $display("FAIL hold_release: got %0d want 8", errCount);
        end
    endtask

    task automatic test_overflow();
        do_clear();
        pulse(8'hFF);
        pulse(8'h3F);
        nchk++;
        if (errCount4 !== 4'd14 || overflow4 !== 1'b0) begin
            nfail++; $display("FAIL ovf_pre: got cnt=%0d ovf=%b want 14/0", errCount4, overflow4);
        end
        pulse(8'h07);
        nchk++;
        if (errCount4 !== 4'hF || overflow4 !== 1'b1) begin
            nfail++; $display("FAIL ovf_sat: got cnt=%h ovf=%b want F/1", errCount4, overflow4);
        end
        nchk++;
        if (errCount !== 16'd17 || overflow !== 1'b0) begin
            nfail++; $display("FAIL ovf_wide: got cnt=%0d ovf=%b want 17/0", errCount, overflow);
        end
        pulse(8'h01);
        nchk++;
        if (errCount4 !== 4'hF || overflow4 !== 1'b1) begin
            nfail++; $display("FAIL ovf_stay: got cnt=%h ovf=%b want F/1", errCount4, overflow4);
        end
    endtask

    task automatic test_snap_clear();
        do_clear();
        pulse(8'h1F);
        nchk++;
        if (errCount !== 16'd5) begin
            nfail++; $display("FAIL snap_setup: got %0d want 5", errCount);
        end
        tmrErr = 8'h04;
        cyc();
        tmrErr = 8'h00; snapReq = 1'b1; clear = 1'b1;
        cyc();
        snapReq = 1'b0; clear = 1'b0;
        nchk++;
        if (snapCount !== 16'd5 || snapFlags !== 8'h1F || snapValid !== 1'b1) begin
            nfail++; $display("FAIL snap_capture: got sc=%0d sf=%h sv=%b want 5/1F/1", snapCount, snapFlags, snapValid);
        end
        nchk++;
        if (errCount !== 16'd1 || errFlags !== 8'h04 || overflow !== 1'b0) begin
            nfail++; $display("FAIL read_clear: got cnt=%0d flg=%h ovf=%b want 1/04/0", errCount, errFlags, overflow);
        end
        nchk++;
        if (overflow4 !== 1'b0 || errCount4 !== 4'd1) begin
            nfail++; $display("FAIL clear_ovf_w4: got cnt=%0d ovf=%b want 1/0", errCount4, overflow4);
        end
        cyc();
        nchk++;
        if (snapValid !== 1'b0 || snapCount !== 16'd5) begin
            nfail++; $display("FAIL snap_pulse: got sv=%b sc=%0d want 0/5", snapValid, snapCount);
        end
    endtask

    task automatic test_back_to_back();
        snapReq = 1'b1; tmrErr = 8'h02;
        cyc();
        tmrErr = 8'h00;
        nchk++;
        if (snapValid !== 1'b1 || snapCount !== 16'd1) begin
            nfail++; $display("FAIL b2b_first: got sv=%b sc=%0d want 1/1", snapValid, snapCount);
        end
        cyc();
        cyc();
        snapReq = 1'b0;
        nchk++;
        if (snapValid !== 1'b1 || snapCount !== 16'd2 || snapFlags !== 8'h06) begin
            nfail++; $display("FAIL b2b_third: got sv=%b sc=%0d sf=%h want 1/2/06", snapValid, snapCount, snapFlags);
        end
        cyc();
        nchk++;
        if (snapValid !== 1'b0) begin
            nfail++; $display("FAIL b2b_end: got sv=%b want 0", snapValid);
        end
    endtask

    task automatic test_alarm();
        do_clear();
        threshold = 16'd3;
        pulse(8'h01);
        pulse(8'h02);
        nchk++;
        if (alarm !== 1'b0 || errCount !== 16'd2) begin
            nfail++; $display("FAIL alarm_below: got alm=%b cnt=%0d want 0/2", alarm, errCount);
        end
        pulse(8'h04);
        nchk++;
        if (alarm !== 1'b0 || errCount !== 16'd3) begin
            nfail++; $display("FAIL alarm_lag: got alm=%b cnt=%0d want 0/3", alarm, errCount);
        end
        cyc();
        nchk++;
        if (alarm !== 1'b1) begin
            nfail++; $display("FAIL alarm_rise: got %b want 1", alarm);
        end
        threshold = 16'd0;
        cyc();
        nchk++;
        if (alarm !== 1'b0) begin
            nfail++; $display("FAIL alarm_disable: got %b want 0", alarm);
        end
    endtask

    task automatic test_enable();
        enable = 1'b0;
        pulse(8'h01);
        pulse(8'h02);
        pulse(8'h10);
        pulse(8'h80);
        enable = 1'b1;
        cyc();
        nchk++;
        if (errCount !== 16'd3 || errFlags !== 8'h07) begin
            nfail++; $display("FAIL enable_freeze: got cnt=%0d flg=%h want 3/07", errCount, errFlags);
        end
    endtask

    task automatic test_reset_mid();
        pulse(8'h10);
        nchk++;
        if (errCount !== 16'd4) begin
            nfail++; $display("FAIL mid_setup: got %0d want 4", errCount);
        end
        snapReq = 1'b1;
        cyc();
        snapReq = 1'b0;
        tmrErr = 8'h20;
        #2 rstn = 1'b0;
        #1;
        nchk++;
        if ({errCount, errFlags, overflow, alarm, snapCount, snapFlags, snapValid} !== 51'd0) begin
            nfail++;
            $display("FAIL async_reset: got cnt=%h flg=%h ovf=%b alm=%b sc=%h sf=%h sv=%b, want all 0",
                     errCount, errFlags, overflow, alarm, snapCount, snapFlags, snapValid);
        end
        cyc();
        rstn = 1'b1;
        cyc(); cyc(); cyc(); cyc();
        nchk++;
        if (errCount !== 16'd1 || errFlags !== 8'h20) begin
            nfail++; $display("FAIL release_high: got cnt=%0d flg=%h want 1/20", errCount, errFlags);
        end
        tmrErr = 8'h00;
        cyc();
    endtask

    initial begin
        test_reset();
        test_single_pulse();
        test_hold();
        test_overflow();
        test_snap_clear();
        test_back_to_back();
        test_alarm();
        test_enable();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
